// File: rtl/pc_ir.sv
// Program counter and instruction register stage for mycpu, with a valid-qualified fetch stall.
// Optional return-address link register enabled by defining MYCPU_PCIR_LINK_EN.
module pc_ir #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        il_in,
  input  logic [1:0]  ps_in,
  input  logic        mm_in,
  input  logic [15:0] bus_a_in,
  input  logic [15:0] mem_rdata_in,
  input  logic        mem_valid_in,
  output logic [15:0] addr_out,
  output logic [15:0] ins_out,
  output logic [15:0] pc_out,
  output logic        stall_out,
  output logic [15:0] link_out
);

  localparam int unsigned W = 16;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_BR   = 2'b10;
  localparam logic [1:0] PS_JMP  = 2'b11;

  logic [0:0]   state_q, state_d;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] ir_q, ir_d;
  logic [W-1:0] br_off;

  // Branch offset always taken from the registered IR, never the incoming word
  assign br_off = {{(W-6){ir_q[8]}}, ir_q[8:6], ir_q[2:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      IDLE: begin
        if (il_in) begin
          if (mem_valid_in) ir_d = mem_rdata_in;
          else              state_d = WAIT;
        end
        case (ps_in)
          PS_HOLD: pc_d = pc_q;
          PS_INC:  pc_d = W'(pc_q + W'(1));
          PS_BR:   pc_d = W'(pc_q + br_off);
          PS_JMP:  pc_d = bus_a_in;
          default: pc_d = pc_q;
        endcase
      end
      WAIT: begin
        if (mem_valid_in) begin
          ir_d    = mem_rdata_in;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MYCPU_PCIR_LINK_EN
  logic [W-1:0] link_q;

  // Return address captured on every accepted jump
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_q <= '0;
    end else if (state_q == IDLE && ps_in == PS_JMP) begin
      link_q <= W'(pc_q + W'(1));
    end
  end

  assign link_out = link_q;
`else
  assign link_out = '0;
`endif

  assign stall_out = (state_q == WAIT);
  assign addr_out  = mm_in ? bus_a_in : pc_q;
  assign ins_out   = ir_q;
  assign pc_out    = pc_q;

endmodule
